svm_score_decide: RTL and testbench
===================================

Name: svm_score_decide

Overview:
- Downstream consumer of the SVM row engine's per-window score stream (svm_data/dvo).
- Adds a signed bias to each window score, saturates the sum to 32 bits and compares it against a threshold.
- Emits a per-window detect flag with its window index.
- At the end of each burst of NWIN = WPI*WINCOLS scores, emits a one-cycle summary: detection count and best-scoring window.

Parameters:
- WPI, 8, windows per image row segment; must match the upstream engine.
- WINCOLS, 8, window columns; must match the upstream engine.
- SWIDTH, 32, score width (signed) of svm_data and all internal scores.
- BWIDTH, 16, signed bias width; sign-extended to SWIDTH+1 internally.

Ports:
- clk, input, 1, single clock; all logic is posedge.
- reset_n, input, 1, asynchronous active-low reset.
- svm_data, input, SWIDTH, signed score from the row engine; valid when dvi=1.
- dvi, input, 1, score valid (driven by the upstream dvo).
- bias, input, BWIDTH, signed bias; sampled at burst start.
- threshold, input, SWIDTH, signed decision threshold; sampled at burst start.
- score_out, output, SWIDTH, biased, saturated score.
- win_idx, output, clog2(NWIN), index of the window in the current burst.
- detect, output, 1, score_out > threshold (strictly greater); qualified by dvo.
- dvo, output, 1, score_out/win_idx/detect valid.
- burst_done, output, 1, one-cycle pulse after the last window of a burst.
- det_count, output, clog2(NWIN)+1, number of detects in the burst; valid with burst_done.
- max_score, output, SWIDTH, highest score_out in the burst; valid with burst_done (SVM_MAXTRACK_EN only).
- max_idx, output, clog2(NWIN), window of max_score; lowest index wins ties (SVM_MAXTRACK_EN only).

Behaviour:
- Reset: all outputs are 0; state=IDLE; idx=0; the bias/threshold latches are 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on dvi=1. The same cycle latches bias and threshold and accepts sample idx 0.
  - RUN: each dvi=1 accepts one sample and increments idx. dvi=0 inserts a gap: idx holds and there is no timeout.
  - RUN -> FLUSH when the sample with idx=NWIN-1 is accepted; idx wraps to 0.
  - FLUSH: waits for the pipeline to drain, pulses burst_done for 1 cycle, then goes to IDLE.
  - A dvi=1 arriving in FLUSH is accepted as idx 0 of the next burst (latches new bias/threshold) and the FSM goes to RUN. burst_done of the old burst still fires; summary registers are double-buffered, so the old summary is not corrupted.
- Pipeline, fixed latency of 2 cycles from dvi to dvo with no backpressure:
  - Stage 1: sum = svm_data + sext(bias_lat), computed in SWIDTH+1 bits, then saturated to [-2^(SWIDTH-1), 2^(SWIDTH-1)-1].
  - Stage 2: register score_out, win_idx and detect = (sat > thr_lat); dvo=1.
- det_count is incremented in stage 2 on detect. It is presented with burst_done and cleared for the next burst on the first accepted sample.
- burst_done asserts exactly 1 cycle after the dvo carrying idx NWIN-1.
- Reset mid-burst discards all partial state; no burst_done is emitted.
- bias/threshold changes mid-burst have no effect until the next burst start.

Optional Feature:
- Macro: SVM_MAXTRACK_EN.
- Defined:
  - Stage 2 tracks the running max and its index: updated when score_out > max, initialised from idx 0.
  - max_score and max_idx are registered with burst_done.
- Undefined:
  - The tracking logic is absent; max_score and max_idx are tied to 0.

Decomposition:
- Shared package svm_pkg holds:
  - NWIN, the index width function, and the saturation limits SAT_MAX/SAT_MIN.
  - The FSM state typedef (IDLE/RUN/FLUSH).
- One natural sub-module: svm_sat_add (combinational biased add with saturation). It is reused by later stages.

Test Plan:
- WPI=WINCOLS=2 (NWIN=4), bias=10, threshold=50, dvi continuous, scores 30,41,40,100:
  - score_out 40,51,50,110; detect 0,1,0,1; win_idx 0..3.
  - dvo 2 cycles after each input; burst_done 1 cycle after the last dvo; det_count=2; max_score=110, max_idx=3.
- Same burst with dvi gaps (1,0,0,1,1,0,1): identical outputs; dvo spacing mirrors the input; no early burst_done.
- Saturation: svm_data=0x7FFFFFF0 with bias=0x7FFF gives score_out=0x7FFFFFFF. svm_data=0x80000005 with bias=-100 gives score_out=0x80000000.
- Back-to-back bursts:
  - The second burst's first dvi arrives on the FLUSH cycle with bias=0.
  - The first burst_done summary is intact; the second burst uses bias 0; det_count restarts from 0.
- Reset asserted after idx 2: all outputs go to 0 immediately; no burst_done. After release, the next burst starts at win_idx 0.
- Ties: scores 5,5,5,5 with SVM_MAXTRACK_EN give max_idx=0. Without the macro, max_score=max_idx=0 throughout.

Source files
------------

// File: rtl/svm_pkg.sv
// svm_pkg - shared definitions for the SVM score decision block.
//
// Contents:
//   DEF_WPI / DEF_WINCOLS / NWIN : default window geometry (NWIN = WPI*WINCOLS)
//   SWIDTH_D, SAT_MAX / SAT_MIN  : default score width and its saturation limits
//   idx_w()                      : width of a window index for a burst of n windows
//   state_t                      : burst FSM states (IDLE / RUN / FLUSH)
package svm_pkg;

    localparam int DEF_WPI     = 8;
    localparam int DEF_WINCOLS = 8;
    localparam int NWIN        = DEF_WPI * DEF_WINCOLS;

    localparam int SWIDTH_D = 32;
    localparam logic signed [SWIDTH_D-1:0] SAT_MAX = {1'b0, {(SWIDTH_D-1){1'b1}}};
    localparam logic signed [SWIDTH_D-1:0] SAT_MIN = {1'b1, {(SWIDTH_D-1){1'b0}}};

    // A single-window burst still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/svm_sat_add.sv
// svm_sat_add - combinational signed add of a score and a narrower bias,
// saturated back to the score width.
//
// Ports:
//   a : W-bit signed score
//   b : BW-bit signed bias (sign-extended to W+1 bits)
//   y : W-bit signed saturated sum
module svm_sat_add #(
    parameter int W  = 32,
    parameter int BW = 16
) (
    input  logic signed [W-1:0]  a,
    input  logic signed [BW-1:0] b,
    output logic signed [W-1:0]  y
);

    logic signed [W:0] sum;

    always_comb begin
        sum = {a[W-1], a} + {{(W+1-BW){b[BW-1]}}, b};
        // The top two bits disagree only when the W-bit result would overflow;
        // the extra bit then carries the true sign, which selects the limit.
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/svm_score_decide.sv
// svm_score_decide - biases, saturates and thresholds the per-window SVM score
// stream, and summarises each burst of NWIN = WPI*WINCOLS windows.
//
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   svm_data, dvi        : incoming signed score and its valid
//   bias, threshold      : signed bias / threshold, latched at each burst start
//   score_out, win_idx,
//   detect, dvo          : per-window result, 2 cycles after the input
//   burst_done           : one-cycle pulse after the last window's dvo
//   det_count            : detect count of the finished burst
//   max_score, max_idx   : best window of the finished burst
//
// Build option: define SVM_MAXTRACK_EN to enable max_score/max_idx tracking;
// otherwise both outputs are tied to 0.
module svm_score_decide
    import svm_pkg::*;
#(
    parameter int WPI     = DEF_WPI,
    parameter int WINCOLS = DEF_WINCOLS,
    parameter int SWIDTH  = SWIDTH_D,
    parameter int BWIDTH  = 16,
    localparam int NW     = WPI * WINCOLS,
    localparam int IW     = idx_w(NW)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [SWIDTH-1:0] svm_data,
    input  logic                     dvi,
    input  logic signed [BWIDTH-1:0] bias,
    input  logic signed [SWIDTH-1:0] threshold,
    output logic signed [SWIDTH-1:0] score_out,
    output logic [IW-1:0]            win_idx,
    output logic                     detect,
    output logic                     dvo,
    output logic                     burst_done,
    output logic [IW:0]              det_count,
    output logic signed [SWIDTH-1:0] max_score,
    output logic [IW-1:0]            max_idx
);

    state_t                     state_reg, state_next;
    logic [IW-1:0]              idx_reg;
    logic signed [BWIDTH-1:0]   bias_lat_reg;
    logic signed [SWIDTH-1:0]   thr_lat_reg;
    logic                       start;
    logic                       last_in;
    logic                       last_out;
    logic signed [BWIDTH-1:0]   bias_eff;
    logic signed [SWIDTH-1:0]   thr_eff;
    logic signed [SWIDTH-1:0]   sat;

    logic                       s1_valid_reg;
    logic signed [SWIDTH-1:0]   s1_sat_reg;
    logic signed [SWIDTH-1:0]   s1_thr_reg;
    logic [IW-1:0]              s1_idx_reg;
    logic                       s1_first;
    logic                       s1_det;
    logic [IW:0]                cnt_run_reg;

    assign last_in  = (idx_reg == IW'(NW - 1));
    assign last_out = dvo && (win_idx == IW'(NW - 1));

    // A burst starts on any sample that arrives outside RUN, including one that
    // lands in FLUSH while the previous burst is still draining.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dvi) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (dvi && last_in) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (dvi) begin
                    start      = 1'b1;
                    state_next = RUN;
                end else if (last_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first sample of a burst must already see the bias/threshold latched
    // on that same cycle, so bypass the latches while they load.
    assign bias_eff = start ? bias : bias_lat_reg;
    assign thr_eff  = start ? threshold : thr_lat_reg;

    svm_sat_add #(
        .W  (SWIDTH),
        .BW (BWIDTH)
    ) u_sat_add (
        .a (svm_data),
        .b (bias_eff),
        .y (sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            bias_lat_reg <= '0;
            thr_lat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                bias_lat_reg <= bias;
                thr_lat_reg  <= threshold;
            end
            if (dvi) begin
                idx_reg <= last_in ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // Stage 1: saturated score, with the threshold in force for this sample
    // carried alongside so a new burst can overlap the old one's drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_sat_reg   <= '0;
            s1_thr_reg   <= '0;
            s1_idx_reg   <= '0;
        end else begin
            s1_valid_reg <= dvi;
            if (dvi) begin
                s1_sat_reg <= sat;
                s1_thr_reg <= thr_eff;
                s1_idx_reg <= idx_reg;
            end
        end
    end

    assign s1_first = (s1_idx_reg == '0);
    assign s1_det   = (s1_sat_reg > s1_thr_reg);

    // Stage 2: per-window outputs plus the running detect count. The summary
    // outputs are a separate register bank, loaded one cycle after the last
    // window, so a following burst can restart the running count freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_out   <= '0;
            win_idx     <= '0;
            detect      <= 1'b0;
            dvo         <= 1'b0;
            cnt_run_reg <= '0;
            burst_done  <= 1'b0;
            det_count   <= '0;
        end else begin
            dvo        <= s1_valid_reg;
            burst_done <= last_out;
            if (s1_valid_reg) begin
                score_out   <= s1_sat_reg;
                win_idx     <= s1_idx_reg;
                detect      <= s1_det;
                cnt_run_reg <= (s1_first ? '0 : cnt_run_reg) + {{IW{1'b0}}, s1_det};
            end
            if (last_out) begin
                det_count <= cnt_run_reg;
            end
        end
    end

`ifdef SVM_MAXTRACK_EN
    logic signed [SWIDTH-1:0] run_max_reg;
    logic [IW-1:0]            run_max_idx_reg;

    // Strict '>' keeps the earliest window on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_max_reg     <= '0;
            run_max_idx_reg <= '0;
            max_score       <= '0;
            max_idx         <= '0;
        end else begin
            if (s1_valid_reg && (s1_first || (s1_sat_reg > run_max_reg))) begin
                run_max_reg     <= s1_sat_reg;
                run_max_idx_reg <= s1_idx_reg;
            end
            if (last_out) begin
                max_score <= run_max_reg;
                max_idx   <= run_max_idx_reg;
            end
        end
    end
`else
    assign max_score = '0;
    assign max_idx   = '0;
`endif

endmodule

// File: tb/tb_svm_score_decide.sv
module tb_svm_score_decide;

    localparam int NW   = 4;
    localparam int TAIL = 4;
    localparam int MAXC = 128;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [31:0] svm_data = '0;
    logic               dvi = 1'b0;
    logic signed [15:0] bias = '0;
    logic signed [31:0] threshold = '0;
    logic signed [31:0] score_out;
    logic [1:0]         win_idx;
    logic               detect;
    logic               dvo;
    logic               burst_done;
    logic [2:0]         det_count;
    logic signed [31:0] max_score;
    logic [1:0]         max_idx;

    int errors = 0;
    int checks = 0;

    svm_score_decide #(
        .WPI     (2),
        .WINCOLS (2),
        .SWIDTH  (32),
        .BWIDTH  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .svm_data   (svm_data),
        .dvi        (dvi),
        .bias       (bias),
        .threshold  (threshold),
        .score_out  (score_out),
        .win_idx    (win_idx),
        .detect     (detect),
        .dvo        (dvo),
        .burst_done (burst_done),
        .det_count  (det_count),
        .max_score  (max_score),
        .max_idx    (max_idx)
    );

    always #5 clk = ~clk;

    // Stimulus table, one entry per cycle.
    logic               s_dvi  [MAXC];
    logic signed [31:0] s_data [MAXC];
    logic signed [15:0] s_bias [MAXC];
    logic signed [31:0] s_thr  [MAXC];
    int                 n_in;

    // Expected and captured outputs, indexed by cycle.
    logic               e_dvo [MAXC], e_det [MAXC], e_bd [MAXC];
    logic signed [31:0] e_score [MAXC], e_max [MAXC];
    logic [1:0]         e_idx [MAXC], e_midx [MAXC];
    logic [2:0]         e_cnt [MAXC];
    logic               c_dvo [MAXC], c_det [MAXC], c_bd [MAXC];
    logic signed [31:0] c_score [MAXC], c_max [MAXC];
    logic [1:0]         c_idx [MAXC], c_midx [MAXC];
    logic [2:0]         c_cnt [MAXC];

    task automatic push(input logic d, input logic signed [31:0] data,
                        input logic signed [15:0] b, input logic signed [31:0] t);
        s_dvi[n_in]  = d;
        s_data[n_in] = data;
        s_bias[n_in] = b;
        s_thr[n_in]  = t;
        n_in++;
    endtask

    function automatic longint clamp(input longint v);
        if (v > LMAX) return LMAX;
        if (v < LMIN) return LMIN;
        return v;
    endfunction

    // Reference model: bursts of NW accepted samples, bias/threshold taken
    // from the first sample of each burst, result 1 cycle after the sampling
    // edge, summary 1 cycle after the last result.
    task automatic build_model;
        int     pos = 0;
        int     cnt = 0;
        int     mi  = 0;
        longint lb  = 0;
        longint lt  = 0;
        longint mx  = 0;
        longint sc;
        for (int j = 0; j < MAXC; j++) begin
            e_dvo[j] = 0; e_det[j] = 0; e_bd[j] = 0; e_score[j] = '0;
            e_max[j] = '0; e_idx[j] = '0; e_midx[j] = '0; e_cnt[j] = '0;
        end
        for (int i = 0; i < n_in; i++) begin
            if (s_dvi[i]) begin
                if (pos == 0) begin
                    lb  = longint'(s_bias[i]);
                    lt  = longint'(s_thr[i]);
                    cnt = 0;
                end
                sc = clamp(longint'(s_data[i]) + lb);
                e_dvo[i+1]   = 1'b1;
                e_score[i+1] = 32'(sc);
                e_idx[i+1]   = 2'(pos);
                e_det[i+1]   = (sc > lt);
                if (sc > lt) cnt++;
                if (pos == 0 || sc > mx) begin
                    mx = sc;
                    mi = pos;
                end
                if (pos == NW - 1) begin
                    e_bd[i+2]  = 1'b1;
                    e_cnt[i+2] = 3'(cnt);
`ifdef SVM_MAXTRACK_EN
                    e_max[i+2]  = 32'(mx);
                    e_midx[i+2] = 2'(mi);
`endif
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
    endtask

    // Drives the stimulus table plus TAIL idle cycles; capture i holds the
    // outputs just after the edge that sampled input i.
    task automatic run_seq;
        @(negedge clk);
        for (int i = 0; i < n_in + TAIL; i++) begin
            if (i < n_in) begin
                dvi = s_dvi[i]; svm_data = s_data[i]; bias = s_bias[i]; threshold = s_thr[i];
            end else begin
                dvi = 1'b0; svm_data = '0;
            end
            @(posedge clk);
            @(negedge clk);
            c_dvo[i] = dvo; c_score[i] = score_out; c_idx[i] = win_idx; c_det[i] = detect;
            c_bd[i] = burst_done; c_cnt[i] = det_count; c_max[i] = max_score; c_midx[i] = max_idx;
            if (dvo)
                $display("out   cyc=%0d idx=%0d score=%h detect=%0b", i, win_idx, score_out, detect);
            if (burst_done)
                $display("burst cyc=%0d det_count=%0d max=%h max_idx=%0d", i, det_count, max_score, max_idx);
        end
        dvi = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({score_out, win_idx, detect, dvo, burst_done, det_count, max_score, max_idx} !== '0) begin
            errors++;
            $display("FAIL reset_hold got score=%h idx=%0d det=%0b dvo=%0b bd=%0b cnt=%0d max=%h midx=%0d exp all 0",
                     score_out, win_idx, detect, dvo, burst_done, det_count, max_score, max_idx);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dvo, burst_done, det_count} !== '0) begin
            errors++;
            $display("FAIL reset_idle got dvo=%0b bd=%0b cnt=%0d exp 0/0/0", dvo, burst_done, det_count);
        end
    endtask

    task automatic test_basic;
        int exp_s [4] = '{40, 51, 50, 110};
        int exp_d [4] = '{0, 1, 0, 1};
        n_in = 0;
        push(1, 30, 10, 50); push(1, 41, 10, 50); push(1, 40, 10, 50); push(1, 100, 10, 50);
        build_model();
        run_seq();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (c_dvo[k+1] !== 1'b1 || c_score[k+1] !== 32'(exp_s[k]) || c_det[k+1] !== exp_d[k][0] || c_idx[k+1] !== 2'(k)) begin
                errors++;
                $display("FAIL basic_fixed k=%0d got dvo=%0b score=%0d det=%0b idx=%0d exp 1/%0d/%0d/%0d",
                         k, c_dvo[k+1], c_score[k+1], c_det[k+1], c_idx[k+1], exp_s[k], exp_d[k], k);
            end
        end
        checks++;
        if (c_bd[5] !== 1'b1 || c_cnt[5] !== 3'd2) begin
            errors++;
            $display("FAIL basic_summary got bd=%0b cnt=%0d exp 1/2", c_bd[5], c_cnt[5]);
        end
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL basic_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL basic_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_gaps;
        n_in = 0;
        push(1, 30, 10, 50); push(0, 0, 10, 50); push(0, 0, 10, 50); push(1, 41, 10, 50);
        push(1, 40, 10, 50); push(0, 0, 10, 50); push(1, 100, 10, 50);
        build_model();
        run_seq();
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL gaps_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL gaps_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_saturation;
        n_in = 0;
        push(1, 32'sh7FFFFFF0, 16'sh7FFF, 0); push(1, 32'sh7FFFFFFF, 16'sh7FFF, 0);
        push(1, 0, 16'sh7FFF, 0);             push(1, -5, 16'sh7FFF, 0);
        push(1, 32'sh80000005, -16'sd100, 0); push(1, 32'sh80000000, -16'sd100, 0);
        push(1, 50, -16'sd100, 0);            push(1, 32'sh7FFFFFFF, -16'sd100, 0);
        build_model();
        run_seq();
        checks++;
        if (c_score[1] !== 32'sh7FFFFFFF) begin
            errors++;
            $display("FAIL sat_pos got %h exp 7fffffff", c_score[1]);
        end
        checks++;
        if (c_score[5] !== 32'sh80000000) begin
            errors++;
            $display("FAIL sat_neg got %h exp 80000000", c_score[5]);
        end
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL sat_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL sat_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_back_to_back;
        n_in = 0;
        push(1, 30, 10, 50); push(1, 41, 10, 50); push(1, 40, 10, 50); push(1, 100, 10, 50);
        // First sample of the second burst lands on the FLUSH cycle.
        push(1, 60, 0, 50);  push(1, 10, 0, 50);  push(1, 70, 0, 50);  push(1, 51, 0, 50);
        build_model();
        run_seq();
        checks++;
        if (c_bd[5] !== 1'b1 || c_cnt[5] !== 3'd2 || c_score[5] !== 32'sd60 || c_bd[9] !== 1'b1 || c_cnt[9] !== 3'd3) begin
            errors++;
            $display("FAIL b2b_fixed got bd5=%0b cnt5=%0d score5=%0d bd9=%0b cnt9=%0d exp 1/2/60/1/3",
                     c_bd[5], c_cnt[5], c_score[5], c_bd[9], c_cnt[9]);
        end
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL b2b_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL b2b_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_ties;
        n_in = 0;
        push(1, 5, 0, 0); push(1, 5, 0, 0); push(1, 5, 0, 0); push(1, 5, 0, 0);
        build_model();
        run_seq();
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL ties_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_random;
        int                 acc = 0;
        logic               d;
        logic signed [31:0] data;
        n_in = 0;
        while (acc < 3 * NW) begin
            d = (n_in > 60) ? 1'b1 : (($urandom % 4) != 0);
            case ($urandom % 6)
                0:       data = 32'sh7FFF0000 + 32'($urandom % 65536);
                1:       data = 32'sh80000000 + 32'($urandom % 65536);
                default: data = 32'($urandom);
            endcase
            // Bias and threshold wander every cycle; only burst starts may use them.
            push(d, data, 16'($urandom), 32'($urandom));
            if (d) acc++;
        end
        build_model();
        run_seq();
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL rand_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL rand_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    task automatic test_midburst_reset;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dvi = 1'b1; svm_data = 32'sd100; bias = '0; threshold = '0;
            @(negedge clk);
        end
        dvi = 1'b0;
        checks++;
        if (dvo !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight got dvo=%0b exp 1", dvo);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({score_out, win_idx, detect, dvo, burst_done, det_count, max_score, max_idx} !== '0) begin
            errors++;
            $display("FAIL mid_reset got score=%h idx=%0d det=%0b dvo=%0b bd=%0b cnt=%0d max=%h midx=%0d exp all 0",
                     score_out, win_idx, detect, dvo, burst_done, det_count, max_score, max_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_in = 0;
        push(1, 1, 0, 2); push(1, 2, 0, 2); push(1, 3, 0, 2); push(1, 4, 0, 2);
        build_model();
        run_seq();
        for (int j = 0; j < n_in + TAIL; j++) begin
            checks++;
            if (c_dvo[j] !== e_dvo[j] || (e_dvo[j] && {c_idx[j], c_det[j], c_score[j]} !== {e_idx[j], e_det[j], e_score[j]})) begin
                errors++;
                $display("FAIL mid_out cyc=%0d got dvo=%0b idx=%0d det=%0b score=%h exp %0b/%0d/%0b/%h",
                         j, c_dvo[j], c_idx[j], c_det[j], c_score[j], e_dvo[j], e_idx[j], e_det[j], e_score[j]);
            end
            checks++;
            if (c_bd[j] !== e_bd[j] || (e_bd[j] && {c_cnt[j], c_max[j], c_midx[j]} !== {e_cnt[j], e_max[j], e_midx[j]})) begin
                errors++;
                $display("FAIL mid_sum cyc=%0d got bd=%0b cnt=%0d max=%h midx=%0d exp %0b/%0d/%h/%0d",
                         j, c_bd[j], c_cnt[j], c_max[j], c_midx[j], e_bd[j], e_cnt[j], e_max[j], e_midx[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_saturation();
        test_back_to_back();
        test_ties();
        test_random();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
